// File: rtl/tt_sweep_pkg.sv
// Shared state encoding, default sizing and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

    localparam int DEFAULT_N_IN   = 4;
    localparam int DEFAULT_SETTLE = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // A settle of one cycle still needs a one-bit counter that simply sits at zero.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable down-counter with a zero flag; times how long each vector is held before sampling.
module tt_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Drives every input vector into an external combinational function and checks it against a golden table.
// Optional macro TT_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = DEFAULT_N_IN,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 f,
    output logic [N_IN-1:0]      x,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail
);

    localparam int NV = 2**N_IN;
    localparam int CW = cnt_width(SETTLE);

    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] X_LAST      = '1;
    localparam logic [N_IN-1:0] X_ONE       = N_IN'(1);
    localparam logic [N_IN:0]   MIS_ONE     = (N_IN + 1)'(1);

    state_t           r_state;
    logic [N_IN-1:0]  r_x;
    logic [NV-1:0]    r_exp;
    logic [NV-1:0]    r_table;
    logic [N_IN:0]    r_mis;
    logic [N_IN-1:0]  r_first;
    logic             r_pass;

    state_t           w_state_next;
    logic             w_mismatch;
    logic             w_last;
    logic             w_end;
    logic             w_cnt_zero;
    logic             w_cnt_load;
    logic             w_cnt_dec;

    assign w_mismatch = (f != r_exp[r_x]);
    assign w_last     = (r_x == X_LAST);

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    assign w_end = w_last || w_mismatch;
`else
    assign w_end = w_last;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   w_state_next = start ? ST_WAIT : ST_IDLE;
            ST_WAIT:   w_state_next = w_cnt_zero ? ST_SAMPLE : ST_WAIT;
            ST_SAMPLE: w_state_next = w_end ? ST_DONE : ST_WAIT;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Reload the settle timer on every entry into WAIT so each vector gets the full hold time.
    assign w_cnt_load = (w_state_next == ST_WAIT) && (r_state != ST_WAIT);
    assign w_cnt_dec  = (r_state == ST_WAIT);

    tt_settle_cnt #(
        .W (CW)
    ) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (w_cnt_dec),
        .zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_exp   <= '0;
            r_table <= '0;
            r_mis   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_exp   <= expected;
                        r_table <= '0;
                        r_mis   <= '0;
                        r_first <= '0;
                        r_pass  <= 1'b0;
                        r_x     <= '0;
                    end
                end
                ST_SAMPLE: begin
                    r_table[r_x] <= f;
                    if (w_mismatch) begin
                        r_mis <= r_mis + MIS_ONE;
                        if (r_mis == '0) begin
                            r_first <= r_x;
                        end
                    end
                    if (!w_end) begin
                        r_x <= r_x + X_ONE;
                    end
                end
                ST_DONE: begin
                    r_pass <= (r_mis == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign x            = r_x;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign pass         = r_pass;
    assign table_out    = r_table;
    assign mismatch_cnt = r_mis;
    assign first_fail   = r_first;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: sweep-level reference model checked every cycle plus literal spot checks.
module tb_tt_sweep_ctrl;

    localparam int NV        = 16;
    localparam int TB_SETTLE = 1;
    localparam int P         = TB_SETTLE + 1;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected = '0;
    logic [15:0] fn_tab = '0;
    logic        f;
    logic [3:0]  x;
    logic        busy, done, pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;

    int n_checks = 0;
    int n_fail   = 0;

    assign f = fn_tab[x];

    always #5 clk = ~clk;

    tt_sweep_ctrl #(
        .N_IN   (4),
        .SETTLE (TB_SETTLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .expected     (expected),
        .f            (f),
        .x            (x),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .table_out    (table_out),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popcount(input logic [15:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NV; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int lowest_set(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = NV - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Number of vectors a sweep samples, given which vectors disagree with the golden table.
    function automatic int sweep_len(input logic [15:0] diff);
        return (STOP_EN && diff != 16'h0) ? lowest_set(diff) + 1 : NV;
    endfunction

    // Lab function f = b&~c | a&b | ~c&d with x = {a,b,c,d}.
    function automatic logic [15:0] lab_table();
        logic [15:0] t;
        logic [3:0]  k;
        for (int i = 0; i < NV; i++) begin
            k = 4'(i);
            t[i] = (k[2] & ~k[1]) | (k[3] & k[2]) | (~k[1] & k[0]);
        end
        return t;
    endfunction

    // Reference model: a sweep is described only by cycles elapsed since the accepting edge.
    bit          m_started = 1'b0;
    int          m_c = 0;
    int          m_len = NV;
    logic [15:0] m_exp = '0;
    logic [15:0] m_fn = '0;

    always begin : cmp
        int ns, ex_x, ex_mis, ex_ff, last;
        logic [15:0] msk, bad, ex_tab;
        logic ex_busy, ex_done, ex_pass;
        @(posedge clk);
        if (rst) begin
            m_started = 1'b0;
            m_c = 0;
        end else if ((!m_started || m_c > P * m_len) && start) begin
            m_started = 1'b1;
            m_c = 0;
            m_exp = expected;
            m_fn = fn_tab;
            m_len = sweep_len(fn_tab ^ expected);
        end else if (m_started && m_c <= P * m_len) begin
            m_c++;
        end
        #1;
        if (!m_started) begin
            ex_x = 0; ex_tab = '0; ex_mis = 0; ex_ff = 0;
            ex_busy = 1'b0; ex_done = 1'b0; ex_pass = 1'b0;
        end else begin
            last = P * m_len;
            ns = m_c / P;
            if (ns > m_len) ns = m_len;
            ex_x = m_c / P;
            if (ex_x > m_len - 1) ex_x = m_len - 1;
            msk = (ns >= NV) ? 16'hFFFF : 16'((32'd1 << ns) - 32'd1);
            bad = (m_fn ^ m_exp) & msk;
            ex_tab  = m_fn & msk;
            ex_mis  = popcount(bad);
            ex_ff   = lowest_set(bad);
            ex_busy = (m_c <= last);
            ex_done = (m_c == last);
            ex_pass = (m_c > last) && (bad == 16'h0);
        end
        check("x", 32'(x), ex_x);
        check("table_out", 32'(table_out), 32'(ex_tab));
        check("mismatch_cnt", 32'(mismatch_cnt), ex_mis);
        check("first_fail", 32'(first_fail), ex_ff);
        check("busy", 32'(busy), 32'(ex_busy));
        check("done", 32'(done), 32'(ex_done));
        check("pass", 32'(pass), 32'(ex_pass));
    end

    // Starts a sweep, optionally re-pulses start mid-sweep, and returns edges from acceptance to done.
    task automatic run_sweep(input logic [15:0] fn, input logic [15:0] ex, input int repulse, output int lat);
        int n;
        bit seen;
        @(negedge clk);
        fn_tab = fn;
        expected = ex;
        start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            start = (repulse != 0 && n == repulse);
            expected = 16'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        lat = n;
    endtask

    initial begin
        int lat, dcount, dlast, rsel;
        logic [15:0] lab, fn, ex;
        lab = lab_table();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_table", 32'(table_out), 0);
        check("rst_pass", 32'(pass), 0);

        // f tied low, all-zero golden table
        run_sweep(16'h0000, 16'h0000, 0, lat);
        check("t1_lat", lat, 32);
        @(posedge clk); #1;
        check("t1_pass", 32'(pass), 1);
        check("t1_table", 32'(table_out), 32'h0000);
        check("t1_mis", 32'(mismatch_cnt), 0);

        run_sweep(lab, 16'hF232, 0, lat);
        check("t2_lat", lat, 32);
        @(posedge clk); #1;
        check("t2_pass", 32'(pass), 1);
        check("t2_table", 32'(table_out), 32'hF232);

        run_sweep(lab, 16'hF233, 0, lat);
        @(posedge clk); #1;
        check("t3_pass", 32'(pass), 0);
        check("t3_mis", 32'(mismatch_cnt), 1);
        check("t3_ff", 32'(first_fail), 0);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        check("t3_lat", lat, 2);
        check("t3_table", 32'(table_out), 32'h0000);
`else
        check("t3_lat", lat, 32);
        check("t3_table", 32'(table_out), 32'hF232);
`endif

        run_sweep(lab, 16'h0DCD, 0, lat);
        @(posedge clk); #1;
        check("t4_ff", 32'(first_fail), 0);
        check("t4_pass", 32'(pass), 0);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        check("t4_mis", 32'(mismatch_cnt), 1);
`else
        check("t4_mis", 32'(mismatch_cnt), 16);
`endif

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        run_sweep(16'hFFFF, 16'h0000, 0, lat);
        check("t4s_lat", lat, 2);
        check("t4s_table", 32'(table_out), 32'h0001);
        check("t4s_mis", 32'(mismatch_cnt), 1);
        check("t4s_ff", 32'(first_fail), 0);
`endif

        // start re-pulsed mid-sweep must be ignored
        run_sweep(lab, 16'hF232, 10, lat);
        check("t5_lat", lat, 32);
        @(posedge clk); #1;
        check("t5_single_done", 32'(done), 0);

        // reset mid-sweep, then a fresh sweep
        @(negedge clk);
        fn_tab = lab; expected = 16'hF232; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_async_busy", 32'(busy), 0);
        check("t6_async_x", 32'(x), 0);
        check("t6_async_table", 32'(table_out), 0);
        check("t6_async_mis", 32'(mismatch_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_sweep(lab, 16'hF232, 0, lat);
        check("t6_lat", lat, 32);
        @(posedge clk); #1;
        check("t6_pass", 32'(pass), 1);
        check("t6_table", 32'(table_out), 32'hF232);

        // start held high through DONE: back-to-back sweeps
        @(negedge clk);
        fn_tab = lab; expected = 16'hF232; start = 1'b1;
        @(posedge clk); #1;
        dcount = 0; dlast = 0;
        for (int n = 1; n <= 67; n++) begin
            @(posedge clk); #1;
            if (done) begin
                dcount++;
                dlast = n;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("t7_done_count", dcount, 2);
        check("t7_second_done", dlast, 66);
        repeat (3) @(negedge clk);

        // randomized sweeps against the model
        for (int i = 0; i < 24; i++) begin
            fn = 16'($urandom);
            rsel = $urandom_range(0, 3);
            case (rsel)
                0: ex = fn;
                1: ex = fn ^ 16'(32'd1 << $urandom_range(0, 15));
                2: ex = 16'($urandom);
                default: ex = ~fn;
            endcase
            run_sweep(fn, ex, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 30) : 0, lat);
            check("rand_lat", lat, P * sweep_len(fn ^ ex));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
